// File: rtl/mem_byte_initiator.sv
// Word-to-byte bus initiator: turns 32-bit read/write requests into four
// little-endian byte accesses on the MainMem port and returns a response.
module mem_byte_initiator #(
  parameter int ACCESS_CYCLES = 1,
  parameter int ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [7:0]        mem_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, TURN, RESP} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(ACCESS_CYCLES - 1);

  state_t            state, state_n;
  logic [1:0]        bidx, bidx_n;
  logic [3:0]        hcnt, hcnt_n;
  logic              we_q, we_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [31:0]       wdata_q, wdata_n;
  logic [31:0]       rdata_q, rdata_n;
  logic              cs_n, oe_n, mwe_n;
  logic [ADDR_W-1:0] maddr_n;
  logic [7:0]        wbyte, wbyte_n;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  // The data bus is only ever driven while the registered WE strobe is high.
  assign mem_data   = mem_we ? wbyte : 8'bz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bidx     <= 2'd0;
      hcnt     <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      mem_cs   <= 1'b0;
      mem_oe   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      wbyte    <= 8'd0;
    end else begin
      state    <= state_n;
      bidx     <= bidx_n;
      hcnt     <= hcnt_n;
      we_q     <= we_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      rdata_q  <= rdata_n;
      mem_cs   <= cs_n;
      mem_oe   <= oe_n;
      mem_we   <= mwe_n;
      mem_addr <= maddr_n;
      wbyte    <= wbyte_n;
    end
  end

  always_comb begin
    state_n = state;
    bidx_n  = bidx;
    hcnt_n  = hcnt;
    we_n    = we_q;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    rdata_n = rdata_q;
    cs_n    = mem_cs;
    oe_n    = mem_oe;
    mwe_n   = mem_we;
    maddr_n = mem_addr;
    wbyte_n = wbyte;
    case (state)
      IDLE: begin
        cs_n  = 1'b0;
        oe_n  = 1'b0;
        mwe_n = 1'b0;
        if (req_valid) begin
          we_n    = req_we;
          addr_n  = req_addr;
          wdata_n = req_wdata;
          rdata_n = 32'd0;
          bidx_n  = 2'd0;
          hcnt_n  = 4'd0;
          state_n = ACCESS;
          // Bus outputs are registered, so byte 0 is presented right away.
          cs_n    = 1'b1;
          mwe_n   = req_we;
          oe_n    = ~req_we;
          maddr_n = req_addr;
          wbyte_n = req_wdata[7:0];
        end
      end
      ACCESS: begin
        if (hcnt == HOLD_LAST) begin
          hcnt_n = 4'd0;
          if (!we_q) rdata_n[8*bidx +: 8] = mem_data;
          if (bidx == 2'd3) begin
            state_n = TURN;
            cs_n    = 1'b0;
            oe_n    = 1'b0;
            mwe_n   = 1'b0;
          end else begin
            bidx_n  = bidx + 2'd1;
            maddr_n = addr_q + ADDR_W'(bidx_n);
            wbyte_n = wdata_q[8*bidx_n +: 8];
          end
        end else begin
          hcnt_n = hcnt + 4'd1;
        end
      end
      TURN: state_n = RESP;
      RESP: if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_byte_initiator.sv
// Bench for mem_byte_initiator: two instances (ACCESS_CYCLES 1 and 3), each
// with a byte memory responder; read results checked through a scoreboard.
module tb_mem_byte_initiator;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  rq_valid = 2'b00;
  logic        rq_we = 1'b0;
  logic [31:0] rq_addr = 32'd0;
  logic [31:0] rq_wdata = 32'd0;
  logic        rs_ready = 1'b1;
  logic [1:0]  rdy, rv, cs, oe, we;
  logic [31:0] rdat [2];
  logic [31:0] ad [2];
  wire  [7:0]  md0, md1;

  logic [7:0]  mm [2][16];   // memory responder contents
  logic [7:0]  rm [2][16];   // reference contents used for expectations
  logic [31:0] exp_q [$];
  int total = 0;
  int bad = 0;

  mem_byte_initiator #(.ACCESS_CYCLES(1), .ADDR_W(32)) u_ac1 (
    .clk(clk), .reset(reset), .req_valid(rq_valid[0]), .req_ready(rdy[0]),
    .req_we(rq_we), .req_addr(rq_addr), .req_wdata(rq_wdata),
    .resp_valid(rv[0]), .resp_ready(rs_ready), .resp_rdata(rdat[0]),
    .mem_cs(cs[0]), .mem_oe(oe[0]), .mem_we(we[0]), .mem_addr(ad[0]), .mem_data(md0));

  mem_byte_initiator #(.ACCESS_CYCLES(3), .ADDR_W(32)) u_ac3 (
    .clk(clk), .reset(reset), .req_valid(rq_valid[1]), .req_ready(rdy[1]),
    .req_we(rq_we), .req_addr(rq_addr), .req_wdata(rq_wdata),
    .resp_valid(rv[1]), .resp_ready(rs_ready), .resp_rdata(rdat[1]),
    .mem_cs(cs[1]), .mem_oe(oe[1]), .mem_we(we[1]), .mem_addr(ad[1]), .mem_data(md1));

  assign md0 = (cs[0] && oe[0]) ? mm[0][ad[0][3:0]] : 8'bz;
  assign md1 = (cs[1] && oe[1]) ? mm[1][ad[1][3:0]] : 8'bz;

  always @(posedge clk) begin
    if (cs[0] && we[0]) mm[0][ad[0][3:0]] <= md0;
    if (cs[1] && we[1]) mm[1][ad[1][3:0]] <= md1;
  end

  function automatic logic [7:0] bus_byte(input int k);
    return (k != 0) ? md1 : md0;
  endfunction

  // Drives one transaction on instance k from accept to response handshake,
  // following the bus cycle by cycle. bp = cycles of response backpressure.
  task automatic drive_and_track(input int k, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input int bp);
    int ac;
    logic [31:0] exp_ad, held, exp_v;
    ac = (k != 0) ? 3 : 1;
    if (w) begin
      for (int i = 0; i < 4; i++) rm[k][4'(a + 32'(i))] = d[8*i +: 8];
      exp_q.push_back(32'd0);
    end else begin
      exp_q.push_back({rm[k][4'(a + 32'd3)], rm[k][4'(a + 32'd2)],
                       rm[k][4'(a + 32'd1)], rm[k][4'(a)]});
    end
    rs_ready = (bp == 0);
    rq_we = w; rq_addr = a; rq_wdata = d; rq_valid[k] = 1'b1;
    total++;
    if (rdy[k] !== 1'b1) begin
      bad++; $display("FAIL accept_ready k=%0d got=%b want=1", k, rdy[k]);
    end
    @(posedge clk); #1;
    rq_valid[k] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int h = 0; h < ac; h++) begin
        exp_ad = a + 32'(b);
        total++;
        if (cs[k] !== 1'b1 || we[k] !== w || oe[k] !== ~w || ad[k] !== exp_ad ||
            rdy[k] !== 1'b0 || rv[k] !== 1'b0 || (w && bus_byte(k) !== d[8*b +: 8])) begin
          bad++;
          $display("FAIL bus k=%0d byte=%0d hold=%0d got cs=%b oe=%b we=%b addr=%h data=%h rdy=%b rv=%b want cs=1 we=%b addr=%h data=%h",
                   k, b, h, cs[k], oe[k], we[k], ad[k], bus_byte(k), rdy[k], rv[k], w, exp_ad, d[8*b +: 8]);
        end
        @(posedge clk); #1;
      end
    end
    total++;
    if (cs[k] !== 1'b0 || oe[k] !== 1'b0 || we[k] !== 1'b0 || rv[k] !== 1'b0) begin
      bad++; $display("FAIL turn k=%0d got cs=%b oe=%b we=%b rv=%b want all 0", k, cs[k], oe[k], we[k], rv[k]);
    end
    @(posedge clk); #1;
    total++;
    if (rv[k] !== 1'b1 || rdy[k] !== 1'b0) begin
      bad++; $display("FAIL latency k=%0d got rv=%b rdy=%b want rv=1 rdy=0", k, rv[k], rdy[k]);
    end
    held = rdat[k];
    for (int i = 0; i < bp; i++) begin
      total++;
      if (rv[k] !== 1'b1 || rdy[k] !== 1'b0 || rdat[k] !== held) begin
        bad++; $display("FAIL backpressure k=%0d cyc=%0d got rv=%b rdy=%b rdata=%h want rv=1 rdy=0 rdata=%h",
                        k, i, rv[k], rdy[k], rdat[k], held);
      end
      rq_valid[k] = (i == bp / 2);
      @(posedge clk); #1;
    end
    rq_valid[k] = 1'b0;
    rs_ready = 1'b1;
    total++;
    if (exp_q.size() == 0) begin
      bad++; $display("FAIL scoreboard_empty k=%0d got rdata=%h want a queued entry", k, rdat[k]);
    end else begin
      exp_v = exp_q.pop_front();
      if (rv[k] !== 1'b1 || rdat[k] !== exp_v) begin
        bad++; $display("FAIL resp_data k=%0d addr=%h got rv=%b rdata=%h want rv=1 rdata=%h", k, a, rv[k], rdat[k], exp_v);
      end
    end
    @(posedge clk); #1;
    total++;
    if (rv[k] !== 1'b0 || rdy[k] !== 1'b1) begin
      bad++; $display("FAIL handshake k=%0d got rv=%b rdy=%b want rv=0 rdy=1", k, rv[k], rdy[k]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (cs[k] !== 1'b0 || oe[k] !== 1'b0 || we[k] !== 1'b0 || ad[k] !== 32'd0 ||
          rv[k] !== 1'b0 || rdat[k] !== 32'd0) begin
        bad++; $display("FAIL reset_state k=%0d got cs=%b oe=%b we=%b addr=%h rv=%b rdata=%h want all 0",
                        k, cs[k], oe[k], we[k], ad[k], rv[k], rdat[k]);
      end
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (rdy[k] !== 1'b1 || rv[k] !== 1'b0) begin
        bad++; $display("FAIL post_reset k=%0d got rdy=%b rv=%b want rdy=1 rv=0", k, rdy[k], rv[k]);
      end
    end
  endtask

  task automatic test_write_ac1();
    drive_and_track(0, 1'b1, 32'h0000_0001, 32'h7654_0005, 0);
  endtask

  task automatic test_read_ac1();
    drive_and_track(0, 1'b0, 32'h0000_0001, 32'h0, 0);
  endtask

  task automatic test_wrap_hold();
    drive_and_track(1, 1'b1, 32'hFFFF_FFFE, 32'h1122_3344, 0);
    drive_and_track(1, 1'b0, 32'hFFFF_FFFE, 32'h0, 0);
  endtask

  task automatic test_backpressure();
    drive_and_track(0, 1'b1, 32'h0000_0005, 32'hCAFE_BABE, 10);
    drive_and_track(0, 1'b0, 32'h0000_0005, 32'h0, 10);
  endtask

  task automatic test_reset_mid_read();
    rq_we = 1'b0; rq_addr = 32'h0000_0001; rq_valid[0] = 1'b1;
    @(posedge clk); #1;
    rq_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    total++;
    if (cs[0] !== 1'b1 || oe[0] !== 1'b1 || ad[0] !== 32'h3) begin
      bad++; $display("FAIL mid_read_byte2 got cs=%b oe=%b addr=%h want cs=1 oe=1 addr=00000003", cs[0], oe[0], ad[0]);
    end
    reset = 1'b1;
    #1;
    total++;
    if (cs[0] !== 1'b0 || oe[0] !== 1'b0 || we[0] !== 1'b0 || ad[0] !== 32'd0 || rv[0] !== 1'b0) begin
      bad++; $display("FAIL async_reset got cs=%b oe=%b we=%b addr=%h rv=%b want all 0", cs[0], oe[0], we[0], ad[0], rv[0]);
    end
    @(negedge clk); @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      total++;
      if (rv[0] !== 1'b0 || rdy[0] !== 1'b1) begin
        bad++; $display("FAIL dropped_txn cyc=%0d got rv=%b rdy=%b want rv=0 rdy=1", i, rv[0], rdy[0]);
      end
    end
    drive_and_track(0, 1'b0, 32'h0000_0002, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d;
    for (int n = 0; n < 3; n++) begin
      a = 32'($urandom_range(9, 12));
      d = $urandom;
      drive_and_track(0, 1'b1, a, d, 0);
      drive_and_track(0, 1'b0, a, 32'h0, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_ac1();
    test_read_ac1();
    test_wrap_hold();
    test_backpressure();
    test_reset_mid_read();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_byte_initiator.md
Name: mem_byte_initiator

Overview:
- Bus initiator for the byte-wide MainMem responder port (clk, CS, OE, WE, 32-bit Addr, 8-bit bidirectional Data).
- Accepts 32-bit word read/write requests from the core or cache side over a valid/ready handshake.
- Sequences each request as four byte accesses on the memory bus, little-endian, and returns read data over a valid/ready response channel.
- Sits between the cache miss/writeback logic and MainMem.

Parameters:
- ACCESS_CYCLES, 1: clock cycles each byte access is held on the bus (range 1..15).
- ADDR_W, 32: memory address width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  byte address of byte 0 of the word.
- req_wdata  input  32  write data; byte i goes to req_addr+i.
- resp_valid  output  1  transaction complete.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  32  read data, byte i from address+i; 0 for writes.
- mem_cs  output  1  MainMem CS.
- mem_oe  output  1  MainMem OE.
- mem_we  output  1  MainMem WE.
- mem_addr  output  ADDR_W  MainMem Addr.
- mem_data  inout  8  MainMem Data; driven only during write accesses, otherwise high-Z.

Behaviour:
- States: IDLE, ACCESS, TURN, RESP. Byte index bidx is 2 bits; hold counter hcnt is 4 bits.
- Reset (asynchronous, effective immediately):
  - state IDLE; bidx=0; hcnt=0.
  - mem_cs=0, mem_oe=0, mem_we=0, mem_addr=0, mem_data released to high-Z.
  - resp_valid=0, resp_rdata=0.
  - req_ready=1 once reset is low, because it is decoded from IDLE.
- Reset mid-transaction: the transaction is dropped with no response. Partial writes already issued to memory are not undone.
- IDLE:
  - req_ready=1; all mem_* strobes 0.
  - On req_valid&&req_ready: latch req_we, req_addr, req_wdata; clear the read buffer; bidx=0, hcnt=0; go to ACCESS.
- ACCESS:
  - req_ready=0.
  - Registered bus outputs: mem_cs=1, mem_we=we, mem_oe=~we, mem_addr=addr+bidx (mod 2^ADDR_W, so 32'hFFFFFFFF+1 wraps to 0).
  - Write: mem_data = wdata[8*bidx+7 : 8*bidx]. Read: mem_data is high-Z.
  - Hold each byte for ACCESS_CYCLES cycles. hcnt increments each cycle.
  - On the edge ending the last hold cycle:
    - Read: sample mem_data into rdata byte bidx.
    - Then hcnt=0. If bidx==3, go to TURN; otherwise bidx+1 and stay in ACCESS. There is no idle gap between bytes.
- TURN:
  - One cycle with mem_cs=mem_oe=mem_we=0 and mem_data high-Z (bus turnaround). Then go to RESP.
- RESP:
  - resp_valid=1; resp_rdata = assembled word (0 for writes); req_ready=0.
  - Hold until resp_valid&&resp_ready, then go to IDLE.
  - resp_rdata remains stable while resp_valid=1.
- Latency: request accepted at edge E → resp_valid high after edge E+4*ACCESS_CYCLES+1. A new request is accepted no earlier than the cycle after the response handshake.
- Simultaneous events:
  - req_valid during ACCESS/TURN/RESP is ignored (req_ready=0).
  - A response handshake and a new req_valid in the same cycle: the request is not accepted until IDLE.
- mem_data is never driven when mem_we=0. The block never drives mem_we and mem_oe high together.

Test Plan:
- Reset then idle: assert reset mid-cycle → all mem_* 0 and mem_data Z asynchronously; after release req_ready=1, resp_valid=0.
- Word write, ACCESS_CYCLES=1: write addr 32'h1, wdata 32'h76540005.
  - Bus shows WE=1 with Addr 1,2,3,4 carrying data 05,00,54,76 on consecutive cycles.
  - resp_valid rises 5 cycles after acceptance; resp_rdata=0.
- Word read back, with a bench memory model responding: read addr 32'h1 → OE=1, WE=0, mem_data Z from the initiator; resp_rdata=32'h76540005.
- Wrap-around and hold: ACCESS_CYCLES=3, write addr 32'hFFFFFFFE.
  - Addresses FFFFFFFE, FFFFFFFF, 0, 1, each held 3 cycles.
  - resp_valid after 13 cycles.
- Response backpressure: hold resp_ready=0 for 10 cycles after completion.
  - resp_valid and resp_rdata stay stable; req_ready stays 0; a req_valid pulse is ignored.
  - After the handshake, the next request is accepted.
- Reset mid-read: assert reset during byte 2 of a read → no resp_valid is ever produced; the next read of 32'h2 completes normally with correct data.
